// File: rtl/addsub4_selftest.sv
// addsub4_selftest: exhaustive self-test sweep of a 4-bit adder/subtractor against a golden model
module addsub4_selftest #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    output logic       mode_o,
    input  logic [3:0] result_i,
    input  logic       cout_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [9:0] err_count,
    output logic [8:0] first_fail,
    output logic       first_fail_valid
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CHECK, S_DONE} state_t;
    localparam logic [3:0] RELOAD = 4'(SETTLE);
    state_t     state_q, state_d;
    logic [8:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic [8:0] vec_q, vec_d;
    logic [9:0] err_q, err_d, err_inc;
    logic [8:0] ff_q, ff_d;
    logic       ffv_q, ffv_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       pass_q, pass_d;
    logic [4:0] gold;
    logic       mism;
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = err_q;
        ff_d    = ff_q;
        ffv_d   = ffv_q;
        busy_d  = busy_q;
        done_d  = done_q;
        pass_d  = pass_q;
        gold    = mode_o ? {1'b0, a_o} + {1'b0, ~b_o} + 5'd1 : {1'b0, a_o} + {1'b0, b_o};
        mism    = {cout_i, result_i} != gold;
        err_inc = err_q + {9'd0, mism};
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_WAIT;
                    idx_d   = 9'd0;
                    vec_d   = 9'd0;
                    cnt_d   = RELOAD;
                    err_d   = 10'd0;
                    ffv_d   = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = S_CHECK;
            end
            S_CHECK: begin
                err_d = err_inc;
                if (mism && !ffv_q) begin
                    ff_d  = idx_q;
                    ffv_d = 1'b1;
                end
                if (idx_q == 9'd511) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = err_inc == 10'd0;
                end else begin
                    state_d = S_WAIT;
                    idx_d   = idx_q + 9'd1;
                    vec_d   = idx_q + 9'd1;
                    cnt_d   = RELOAD;
                end
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 9'd0;
            cnt_q   <= 4'd0;
            vec_q   <= 9'd0;
            err_q   <= 10'd0;
            ff_q    <= 9'd0;
            ffv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            ffv_q   <= ffv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end
    assign {mode_o, a_o, b_o} = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail       = ff_q;
    assign first_fail_valid = ffv_q;
endmodule

// File: tb/tb_addsub4_selftest.sv
// tb_addsub4_selftest: directed checks of the self-test engine against healthy and faulty adder models
module tb_addsub4_selftest;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start1 = 1'b0, start3 = 1'b0;
    int   fault = 0;
    int   cmp = 0, bad = 0;
    always #5 clk = ~clk;

    logic [3:0] a1, b1, r1, a3, b3, r3;
    logic       m1, c1, busy1, done1, pass1, ffv1;
    logic       m3, c3, busy3, done3, pass3, ffv3;
    logic [9:0] err1, err3;
    logic [8:0] ff1, ff3;

    function automatic logic [4:0] model(input logic [3:0] a, input logic [3:0] b, input logic m, input int f);
        logic [4:0] s;
        s = (m && f != 3) ? {1'b0, a} + {1'b0, ~b} + 5'd1 : {1'b0, a} + {1'b0, b};
        if (f == 1) s[0] = 1'b0;
        if (f == 2) s[4] = ~s[4];
        return s;
    endfunction

    assign {c1, r1} = model(a1, b1, m1, fault);
    assign {c3, r3} = model(a3, b3, m3, fault);

    addsub4_selftest #(.SETTLE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_o(a1), .b_o(b1), .mode_o(m1),
        .result_i(r1), .cout_i(c1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_fail(ff1), .first_fail_valid(ffv1));
    addsub4_selftest #(.SETTLE(3)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .a_o(a3), .b_o(b3), .mode_o(m3),
        .result_i(r3), .cout_i(c3), .busy(busy3), .done(done3), .pass(pass3),
        .err_count(err3), .first_fail(ff3), .first_fail_valid(ffv3));

    task automatic kick1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
    endtask

    task automatic finish1(output int n);
        n = 0;
        while (!done1 && n < 3000) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic test_reset;
        #1;
        cmp++;
        if ({a1, b1, m1, busy1, done1, pass1, err1, ff1, ffv1} !== 35'd0) begin
            bad++;
            $display("FAIL reset_s1: got %h want 0", {a1, b1, m1, busy1, done1, pass1, err1, ff1, ffv1});
        end
        cmp++;
        if ({a3, b3, m3, busy3, done3, pass3, err3, ff3, ffv3} !== 35'd0) begin
            bad++;
            $display("FAIL reset_s3: got %h want 0", {a3, b3, m3, busy3, done3, pass3, err3, ff3, ffv3});
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_pass_sweep;
        int n;
        fault = 0;
        kick1;
        cmp++;
        if ({busy1, done1, m1, a1, b1} !== 11'b10_000000000) begin
            bad++;
            $display("FAIL start_edge: got busy=%b done=%b vec=%0d want busy=1 done=0 vec=0", busy1, done1, {m1, a1, b1});
        end
        n = 0;
        while (!done1 && n < 3000) begin
            @(posedge clk);
            #1 n++;
            if (n == 2) begin
                cmp++;
                if ({m1, a1, b1} !== 9'd1) begin
                    bad++;
                    $display("FAIL vec1: got %0d want 1", {m1, a1, b1});
                end
            end
            if (n == 1022) begin
                cmp++;
                if ({m1, a1, b1} !== 9'd511 || busy1 !== 1'b1) begin
                    bad++;
                    $display("FAIL vec511: got %0d busy=%b want 511 busy=1", {m1, a1, b1}, busy1);
                end
            end
        end
        cmp++;
        if (n !== 1024) begin
            bad++;
            $display("FAIL sweep_len_s1: got %0d want 1024", n);
        end
        cmp++;
        if ({busy1, done1, pass1, err1, ffv1} !== {3'b011, 10'd0, 1'b0}) begin
            bad++;
            $display("FAIL good_result: got busy=%b done=%b pass=%b err=%0d ffv=%b want 0 1 1 0 0", busy1, done1, pass1, err1, ffv1);
        end
    endtask

    task automatic test_stuck_lsb;
        int n;
        fault = 1;
        kick1;
        finish1(n);
        cmp++;
        if ({done1, pass1, err1, ff1, ffv1} !== {2'b10, 10'd256, 9'd1, 1'b1}) begin
            bad++;
            $display("FAIL stuck_lsb: got done=%b pass=%b err=%0d ff=%0d ffv=%b want 1 0 256 1 1", done1, pass1, err1, ff1, ffv1);
        end
    endtask

    task automatic test_back_to_back;
        int n;
        fault = 0;
        kick1;
        cmp++;
        if ({busy1, done1, pass1, err1, ffv1} !== {3'b100, 10'd0, 1'b0}) begin
            bad++;
            $display("FAIL restart_clear: got busy=%b done=%b pass=%b err=%0d ffv=%b want 1 0 0 0 0", busy1, done1, pass1, err1, ffv1);
        end
        finish1(n);
        cmp++;
        if ({n == 1024, done1, pass1, err1, ffv1} !== {3'b111, 10'd0, 1'b0}) begin
            bad++;
            $display("FAIL second_run: got n=%0d done=%b pass=%b err=%0d ffv=%b want 1024 1 1 0 0", n, done1, pass1, err1, ffv1);
        end
    endtask

    task automatic test_cout_inv;
        int n;
        fault = 2;
        kick1;
        finish1(n);
        cmp++;
        if ({done1, pass1, err1, ff1, ffv1} !== {2'b10, 10'd512, 9'd0, 1'b1}) begin
            bad++;
            $display("FAIL cout_inv: got done=%b pass=%b err=%0d ff=%0d ffv=%b want 1 0 512 0 1", done1, pass1, err1, ff1, ffv1);
        end
    endtask

    task automatic test_ignore_mode;
        int n;
        fault = 3;
        kick1;
        finish1(n);
        cmp++;
        if ({done1, pass1, err1, ff1, ffv1} !== {2'b10, 10'd240, 9'd256, 1'b1}) begin
            bad++;
            $display("FAIL ignore_mode: got done=%b pass=%b err=%0d ff=%0d ffv=%b want 1 0 240 256 1", done1, pass1, err1, ff1, ffv1);
        end
    endtask

    task automatic test_reset_mid_s3;
        int n;
        fault = 0;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
        end
        cmp++;
        if (busy3 !== 1'b1 || {m3, a3, b3} !== 9'd75) begin
            bad++;
            $display("FAIL mid_run: got busy=%b vec=%0d want busy=1 vec=75", busy3, {m3, a3, b3});
        end
        #2 rst_n = 1'b0;
        #1;
        cmp++;
        if ({a3, b3, m3, busy3, done3, pass3, err3, ff3, ffv3} !== 35'd0) begin
            bad++;
            $display("FAIL async_reset: got %h want 0", {a3, b3, m3, busy3, done3, pass3, err3, ff3, ffv3});
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        n = 0;
        while (!done3 && n < 5000) begin
            start3 = (n == 100 || n == 1500);
            @(posedge clk);
            #1 n++;
        end
        start3 = 1'b0;
        cmp++;
        if (n !== 2048) begin
            bad++;
            $display("FAIL sweep_len_s3: got %0d want 2048", n);
        end
        cmp++;
        if ({busy3, done3, pass3, err3, ffv3} !== {3'b011, 10'd0, 1'b0}) begin
            bad++;
            $display("FAIL s3_result: got busy=%b done=%b pass=%b err=%0d ffv=%b want 0 1 1 0 0", busy3, done3, pass3, err3, ffv3);
        end
    endtask

    initial begin
        test_reset;
        test_pass_sweep;
        test_stuck_lsb;
        test_back_to_back;
        test_cout_inv;
        test_ignore_mode;
        test_reset_mid_s3;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule
